// File: rtl/pico_mem_bridge.sv
// Registered bridge from a picorv32-style valid/ready memory port to a tile-local
// enable/stall SRAM port, with range checking, a stall watchdog and sticky error capture.
module pico_mem_bridge #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                RD_LATENCY  = 1,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT  = 32'h0001_0000,
  parameter int                TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  core_valid_i,
  input  logic                  core_instr_i,
  input  logic [ADDR_W-1:0]     core_addr_i,
  input  logic [DATA_W-1:0]     core_wdata_i,
  input  logic [DATA_W/8-1:0]   core_wstrb_i,
  output logic                  core_ready_o,
  output logic [DATA_W-1:0]     core_rdata_o,
  output logic                  mem_en_o,
  output logic [DATA_W/8-1:0]   mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  input  logic                  mem_stall_i,
  output logic                  err_o,
  output logic [ADDR_W-1:0]     err_addr_o,
  output logic [1:0]            err_type_o,
  output logic                  err_instr_o,
  input  logic                  err_clr_i,
  output logic                  busy_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int WD_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
  localparam bit              WD_EN    = (TIMEOUT_CYC > 0);
  localparam logic [1:0]      LAT_LOAD = 2'(RD_LATENCY - 1);
  localparam logic [1:0]      ERR_RANGE   = 2'b01;
  localparam logic [1:0]      ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_instr;
  logic [1:0]          r_latCnt;
  logic [WD_W-1:0]     r_wdogCnt;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [1:0]          r_errType;
  logic [ADDR_W-1:0]   r_errAddr;
  logic                r_errInstr;

  state_t              w_nextState;
  logic                w_outOfRange;
  logic                w_reqLoad;
  logic                w_rangeErr;
  logic                w_timeout;
  logic                w_accept;
  logic                w_capture;
  logic                w_errEvent;
  logic [1:0]          w_errKind;
  logic [ADDR_W-1:0]   w_errAddr;
  logic                w_errInstr;

  assign w_outOfRange = (core_addr_i >= ADDR_LIMIT);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The watchdog is checked only after acceptance fails, so an unstalled cycle always wins.
  always_comb begin
    w_nextState = r_state;
    w_reqLoad   = 1'b0;
    w_rangeErr  = 1'b0;
    w_timeout   = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (core_valid_i) begin
          w_reqLoad = 1'b1;
          if (w_outOfRange) begin
            w_rangeErr  = 1'b1;
            w_nextState = S_RESP;
          end else begin
            w_nextState = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!mem_stall_i) begin
          w_accept    = 1'b1;
          w_nextState = (|r_wstrb) ? S_RESP : S_WAIT;
        end else if (WD_EN && (r_wdogCnt == WD_LAST)) begin
          w_timeout   = 1'b1;
          w_nextState = S_RESP;
        end
      end
      S_WAIT: begin
        if (r_latCnt == 2'd0) begin
          w_capture   = 1'b1;
          w_nextState = S_RESP;
        end
      end
      S_RESP: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_instr <= 1'b0;
    end else if (w_reqLoad) begin
      r_addr  <= core_addr_i;
      r_wdata <= core_wdata_i;
      r_wstrb <= core_wstrb_i;
      r_instr <= core_instr_i;
    end
  end

  // Outside ISSUE the watchdog sits at zero, which also resets it on every entry.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_wdogCnt <= '0;
      r_latCnt  <= 2'd0;
    end else begin
      if (r_state != S_ISSUE) begin
        r_wdogCnt <= '0;
      end else if (mem_stall_i) begin
        r_wdogCnt <= r_wdogCnt + WD_W'(1);
      end
      if (w_accept) begin
        r_latCnt <= LAT_LOAD;
      end else if ((r_state == S_WAIT) && (r_latCnt != 2'd0)) begin
        r_latCnt <= r_latCnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_rdata <= '0;
    end else if (w_rangeErr || w_timeout) begin
      r_rdata <= ERR_RDATA;
    end else if (w_capture) begin
      r_rdata <= mem_rdata_i;
    end
  end

  always_comb begin
    w_errEvent = w_rangeErr | w_timeout;
    w_errKind  = w_rangeErr ? ERR_RANGE : ERR_TIMEOUT;
    w_errAddr  = w_rangeErr ? core_addr_i : r_addr;
    w_errInstr = w_rangeErr ? core_instr_i : r_instr;
  end

  // A fresh error on the clearing edge is latched in place of the acknowledged one.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_err      <= 1'b0;
      r_errType  <= 2'b00;
      r_errAddr  <= '0;
      r_errInstr <= 1'b0;
    end else if (w_errEvent && (!r_err || err_clr_i)) begin
      r_err      <= 1'b1;
      r_errType  <= w_errKind;
      r_errAddr  <= w_errAddr;
      r_errInstr <= w_errInstr;
    end else if (err_clr_i) begin
      r_err      <= 1'b0;
      r_errType  <= 2'b00;
    end
  end

  assign core_ready_o = (r_state == S_RESP);
  assign core_rdata_o = r_rdata;
  assign mem_en_o     = (r_state == S_ISSUE);
  assign mem_we_o     = (r_state == S_ISSUE) ? r_wstrb : '0;
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign err_o        = r_err;
  assign err_type_o   = r_errType;
  assign err_addr_o   = r_errAddr;
  assign err_instr_o  = r_errInstr;
  assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_pico_mem_bridge.sv
// Randomised bench for pico_mem_bridge: a transaction-level model predicts every output
// per cycle from request, stall plan and error rules; a few literal checks pin the model.
module tb_pico_mem_bridge;

  localparam int          LAT   = 3;
  localparam int          TMO   = 8;
  localparam logic [31:0] LIMIT = 32'h0001_0000;
  localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;

  logic        clk_i        = 1'b0;
  logic        resetn_i     = 1'b0;
  logic        core_valid_i = 1'b0;
  logic        core_instr_i = 1'b0;
  logic [31:0] core_addr_i  = 32'h0;
  logic [31:0] core_wdata_i = 32'h0;
  logic [3:0]  core_wstrb_i = 4'h0;
  logic        core_ready_o;
  logic [31:0] core_rdata_o;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_stall_i  = 1'b0;
  logic        err_o;
  logic [31:0] err_addr_o;
  logic [1:0]  err_type_o;
  logic        err_instr_o;
  logic        err_clr_i    = 1'b0;
  logic        busy_o;

  pico_mem_bridge #(
    .DATA_W(32), .ADDR_W(32), .RD_LATENCY(LAT), .ADDR_LIMIT(LIMIT),
    .TIMEOUT_CYC(TMO), .ERR_RDATA(ERRD)
  ) dut (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .core_valid_i(core_valid_i), .core_instr_i(core_instr_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_wstrb_i(core_wstrb_i),
    .core_ready_o(core_ready_o), .core_rdata_o(core_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_stall_i(mem_stall_i),
    .err_o(err_o), .err_addr_o(err_addr_o), .err_type_o(err_type_o),
    .err_instr_o(err_instr_o), .err_clr_i(err_clr_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory environment: returns read data exactly LAT cycles after acceptance, noise otherwise.
  logic [31:0]    envMem [0:255];
  logic           envInit = 1'b0;
  logic [31:0]    pipeData [0:LAT-1];
  logic [LAT-1:0] pipeVld = '0;
  logic [31:0]    noise   = 32'h0;

  always @(posedge clk_i) begin
    if (!envInit) begin
      for (int i = 0; i < 256; i++) envMem[i] <= 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
      envInit <= 1'b1;
    end
    noise <= $urandom;
    for (int k = 0; k < LAT - 1; k++) begin
      pipeData[k] <= pipeData[k+1];
      pipeVld[k]  <= pipeVld[k+1];
    end
    pipeVld[LAT-1]  <= 1'b0;
    pipeData[LAT-1] <= $urandom;
    if (mem_en_o && !mem_stall_i) begin
      if (mem_we_o != 4'b0) begin
        for (int b = 0; b < 4; b++)
          if (mem_we_o[b]) envMem[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        pipeVld[LAT-1]  <= 1'b1;
        pipeData[LAT-1] <= envMem[mem_addr_o[9:2]];
      end
    end
  end

  assign mem_rdata_i = pipeVld[0] ? pipeData[0] : noise;

  // Reference model state and per-cycle expectations.
  logic [31:0] shMem [0:255];
  logic        mErr = 1'b0;
  logic [1:0]  mType = 2'b00;
  logic [31:0] mAddr = 32'h0;
  logic        mInstr = 1'b0;

  logic        chkEn = 1'b0;
  logic        expReady, expMemEn, expBusy, expRdChk;
  logic [3:0]  expWe;
  logic [31:0] expAddr, expWdata, expRdata;
  int          clrOdds = 0;

  int nVec = 0;
  int nMis = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVec++;
    if (actual !== expected) begin
      nMis++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
    end
  endtask

  always @(negedge clk_i) begin
    if (chkEn) begin
      checkOutput("core_ready", 32'(core_ready_o), 32'(expReady));
      checkOutput("mem_en", 32'(mem_en_o), 32'(expMemEn));
      checkOutput("mem_we", 32'(mem_we_o), 32'(expWe));
      checkOutput("busy", 32'(busy_o), 32'(expBusy));
      checkOutput("err", 32'(err_o), 32'(mErr));
      checkOutput("err_type", 32'(err_type_o), 32'(mType));
      checkOutput("err_addr", err_addr_o, mAddr);
      checkOutput("err_instr", 32'(err_instr_o), 32'(mInstr));
      if (expMemEn) begin
        checkOutput("mem_addr", mem_addr_o, expAddr);
        checkOutput("mem_wdata", mem_wdata_o, expWdata);
      end
      if (expRdChk) checkOutput("core_rdata", core_rdata_o, expRdata);
    end
  end

  function automatic logic randClr();
    return (clrOdds != 0) && ($urandom_range(0, clrOdds - 1) == 0);
  endfunction

  task automatic modelErrEdge(input logic ev, input logic [1:0] kind, input logic [31:0] a,
                              input logic ins, input logic clr);
    if (ev && (!mErr || clr)) begin
      mErr = 1'b1; mType = kind; mAddr = a; mInstr = ins;
    end else if (clr) begin
      mErr = 1'b0; mType = 2'b00;
    end
  endtask

  task automatic setIdle(input logic clr);
    core_valid_i = 1'b0;
    core_addr_i  = $urandom;
    core_wstrb_i = 4'($urandom_range(0, 15));
    core_wdata_i = $urandom;
    core_instr_i = 1'($urandom_range(0, 1));
    mem_stall_i  = 1'($urandom_range(0, 1));
    err_clr_i    = clr;
    expReady = 1'b0; expMemEn = 1'b0; expWe = 4'h0; expBusy = 1'b0; expRdChk = 1'b0;
  endtask

  task automatic idleCycles(input int n, input logic forceClr);
    logic clr;
    for (int i = 0; i < n; i++) begin
      clr = forceClr || randClr();
      setIdle(clr);
      @(negedge clk_i); #1;
      modelErrEdge(1'b0, 2'b00, 32'h0, 1'b0, clr);
      @(posedge clk_i); #1;
    end
  endtask

  // One core transaction: the stall plan holds stall high for nStall cycles after issue.
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] wstrb,
                               input logic [31:0] wdata, input logic instr,
                               input int nStall, input int abortAt,
                               output int obsRdy, output logic [31:0] obsRd);
    logic       isRange, isWrite, isTmo, clr;
    int         enLast, rdyOff;
    logic [1:0] kind;
    isRange = (addr >= LIMIT);
    isWrite = (wstrb != 4'b0);
    isTmo   = !isRange && (nStall >= TMO);
    enLast  = isRange ? 0 : (isTmo ? TMO : nStall + 1);
    rdyOff  = isRange ? 1 : (isTmo ? TMO + 1 : (isWrite ? nStall + 2 : nStall + 2 + LAT));
    kind    = isRange ? 2'b01 : (isTmo ? 2'b10 : 2'b00);
    obsRdy  = -1;
    obsRd   = 32'h0;
    for (int k = 0; k <= rdyOff; k++) begin
      core_valid_i = 1'b1; core_addr_i = addr; core_wstrb_i = wstrb;
      core_wdata_i = wdata; core_instr_i = instr;
      if (!isRange && k >= 1 && k <= nStall)   mem_stall_i = 1'b1;
      else if (!isRange && k == nStall + 1)    mem_stall_i = 1'b0;
      else                                     mem_stall_i = 1'($urandom_range(0, 1));
      clr = randClr();
      err_clr_i = clr;
      expReady = (k == rdyOff);
      expMemEn = (k >= 1) && (k <= enLast);
      expWe    = expMemEn ? wstrb : 4'h0;
      expAddr  = addr;
      expWdata = wdata;
      expBusy  = (k >= 1);
      expRdChk = (k == rdyOff) && ((kind != 2'b00) || !isWrite);
      expRdata = (kind != 2'b00) ? ERRD : shMem[addr[9:2]];
      if (k == abortAt) begin
        #1 resetn_i = 1'b0;
        mErr = 1'b0; mType = 2'b00; mAddr = 32'h0; mInstr = 1'b0;
        expReady = 1'b0; expMemEn = 1'b0; expWe = 4'h0; expBusy = 1'b0;
        expRdChk = 1'b1; expRdata = 32'h0;
        #1;
        checkOutput("async_rst_mem_en", 32'(mem_en_o), 32'h0);
        checkOutput("async_rst_busy", 32'(busy_o), 32'h0);
        checkOutput("async_rst_ready", 32'(core_ready_o), 32'h0);
        checkOutput("async_rst_rdata", core_rdata_o, 32'h0);
        @(negedge clk_i);
        @(posedge clk_i); #1;
        resetn_i = 1'b1;
        setIdle(1'b0);
        return;
      end
      @(negedge clk_i); #1;
      if (core_ready_o && obsRdy < 0) begin
        obsRdy = k;
        obsRd  = core_rdata_o;
      end
      modelErrEdge((kind != 2'b00) && (k == rdyOff - 1), kind, addr, instr, clr);
      @(posedge clk_i); #1;
    end
    if (!isRange && !isTmo && isWrite)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) shMem[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
    setIdle(1'b0);
  endtask

  initial begin
    int          r;
    logic [31:0] d;
    logic [31:0] addr;
    logic [3:0]  strb;
    int          ns;
    for (int i = 0; i < 256; i++) shMem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    expReady = 1'b0; expMemEn = 1'b0; expWe = 4'h0; expBusy = 1'b0;
    expAddr = 32'h0; expWdata = 32'h0; expRdChk = 1'b1; expRdata = 32'h0;
    chkEn = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 resetn_i = 1'b1;
    setIdle(1'b0);
    idleCycles(2, 1'b0);

    $display("[TB] directed transactions");
    applyStimulus(32'h100, 4'hF, 32'hCAFE_0001, 1'b0, 0, -1, r, d);
    checkOutput("wr_latency", 32'(r), 32'd2);
    applyStimulus(32'h100, 4'h0, 32'h0, 1'b0, 0, -1, r, d);
    checkOutput("rd_latency", 32'(r), 32'd5);
    checkOutput("rd_data", d, 32'hCAFE_0001);
    applyStimulus(32'h200, 4'hF, 32'hFFFF_0000, 1'b0, 0, -1, r, d);
    applyStimulus(32'h200, 4'b0011, 32'h1234_ABCD, 1'b0, 3, -1, r, d);
    checkOutput("wr_stall_latency", 32'(r), 32'd5);
    applyStimulus(32'h200, 4'h0, 32'h0, 1'b0, 1, -1, r, d);
    checkOutput("rd_stall_latency", 32'(r), 32'd6);
    checkOutput("rd_strobe_merge", d, 32'hFFFF_ABCD);
    applyStimulus(32'h40, 4'h0, 32'h0, 1'b0, TMO - 1, -1, r, d);
    checkOutput("rd_max_stall_latency", 32'(r), 32'd12);
    checkOutput("rd_max_stall_data", d, 32'h5A10_2030);
    checkOutput("no_err_below_timeout", 32'(err_o), 32'h0);

    applyStimulus(32'h0001_0000, 4'h0, 32'h0, 1'b0, 0, -1, r, d);
    checkOutput("range_latency", 32'(r), 32'd1);
    checkOutput("range_rdata", d, 32'hDEAD_BEEF);
    checkOutput("range_err", 32'(err_o), 32'h1);
    checkOutput("range_type", 32'(err_type_o), 32'h1);
    checkOutput("range_addr", err_addr_o, 32'h0001_0000);
    applyStimulus(32'h0002_0000, 4'hF, 32'h1111_1111, 1'b1, 0, -1, r, d);
    checkOutput("second_err_addr_kept", err_addr_o, 32'h0001_0000);
    checkOutput("second_err_instr_kept", 32'(err_instr_o), 32'h0);
    idleCycles(1, 1'b1);
    checkOutput("clr_err", 32'(err_o), 32'h0);
    checkOutput("clr_type", 32'(err_type_o), 32'h0);

    applyStimulus(32'h80, 4'h0, 32'h0, 1'b1, 20, -1, r, d);
    checkOutput("tmo_latency", 32'(r), 32'd9);
    checkOutput("tmo_rdata", d, 32'hDEAD_BEEF);
    checkOutput("tmo_type", 32'(err_type_o), 32'h2);
    checkOutput("tmo_instr", 32'(err_instr_o), 32'h1);
    checkOutput("tmo_addr", err_addr_o, 32'h80);
    idleCycles(1, 1'b1);

    applyStimulus(32'h200, 4'h0, 32'h0, 1'b0, 0, 3, r, d);
    idleCycles(2, 1'b0);
    applyStimulus(32'h100, 4'h0, 32'h0, 1'b0, 0, -1, r, d);
    checkOutput("post_reset_latency", 32'(r), 32'd5);
    checkOutput("post_reset_rdata", d, 32'hCAFE_0001);

    $display("[TB] randomised transactions");
    clrOdds = 8;
    for (int t = 0; t < 160; t++) begin
      if ($urandom_range(0, 9) == 0) addr = LIMIT + (32'($urandom_range(0, 32'hFFFFF)) << 2);
      else                           addr = 32'($urandom_range(0, 255)) << 2;
      strb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      ns   = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 1, TMO + 3) : $urandom_range(0, 3);
      applyStimulus(addr, strb, $urandom, 1'($urandom_range(0, 1)), ns, -1, r, d);
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 2), 1'b0);
    end
    clrOdds = 0;
    idleCycles(2, 1'b0);

    chkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/pico_mem_bridge.md
Name: pico_mem_bridge

Overview:
- Registered adapter between a picorv32-style native memory port (valid/ready, one outstanding request) and a tile-local SRAM/NoC port (enable/stall).
- Generalises the single fixed-latency stall adapter:
  - read latency is parametrised,
  - out-of-range addresses are rejected with a bus error,
  - a stall watchdog aborts hung accesses.
- Sits between the core wrapper and accelerator-domain memory; error status is routed to the tile's interrupt logic.

Parameters:
- DATA_W, 32, data width; must be a multiple of 8.
- ADDR_W, 32, address width.
- RD_LATENCY, 1, cycles from accepted read to valid mem_rdata_i; legal range 1..4.
- ADDR_LIMIT, 32'h0001_0000, first illegal byte address; any access with address >= ADDR_LIMIT is an error.
- TIMEOUT_CYC, 255, maximum stalled cycles in ISSUE before abort; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on any error.

Ports:
- clk_i  in  1  clock
- resetn_i  in  1  reset, asynchronous, active-low
- core_valid_i  in  1  core request valid
- core_instr_i  in  1  request is an instruction fetch
- core_addr_i  in  ADDR_W  request address
- core_wdata_i  in  DATA_W  write data
- core_wstrb_i  in  DATA_W/8  byte strobes; all zero means read
- core_ready_o  out  1  one-cycle response pulse
- core_rdata_o  out  DATA_W  registered read data, valid while core_ready_o=1
- mem_en_o  out  1  memory request
- mem_we_o  out  DATA_W/8  write strobes
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data
- mem_stall_i  in  1  memory not accepting this cycle
- err_o  out  1  sticky error flag
- err_addr_o  out  ADDR_W  address of first unacknowledged error
- err_type_o  out  2  01 = range, 10 = timeout
- err_instr_o  out  1  failing access was a fetch
- err_clr_i  in  1  clears err_o and err_type_o
- busy_o  out  1  state != IDLE

Behaviour:
- Reset values:
  - state = IDLE.
  - core_ready_o, mem_en_o, mem_we_o, err_o, err_instr_o, busy_o = 0.
  - err_type_o = 0; all data and address registers = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - core_valid_i is sampled only in IDLE.
  - On valid, register addr, wdata, wstrb and instr.
  - If addr >= ADDR_LIMIT: next state RESP with the range error path.
  - Otherwise: next state ISSUE.
- ISSUE:
  - mem_en_o = 1; mem_we_o, mem_addr_o and mem_wdata_o come from the registered request.
  - The request is accepted at a clock edge where mem_en_o=1 and mem_stall_i=0.
  - Write accepted: next state RESP.
  - Read accepted: next state WAIT, latency counter loaded with RD_LATENCY-1.
- Watchdog:
  - Counts consecutive stalled ISSUE cycles.
  - When the count reaches TIMEOUT_CYC while still stalled, the access is aborted: next state RESP with the timeout error path, mem_en_o drops.
  - The count resets on entry to ISSUE.
- WAIT:
  - mem_en_o = 0; the counter decrements each cycle, independent of mem_stall_i.
  - On the edge where the counter = 0, capture mem_rdata_i into core_rdata_o and go to RESP.
  - With RD_LATENCY=1, mem_rdata_i is captured at the edge one cycle after acceptance.
- RESP:
  - core_ready_o = 1 for exactly one cycle; next state IDLE.
  - core_valid_i is ignored in RESP, so a back-to-back request is sampled in the following IDLE cycle.
- Latency, core valid to ready:
  - write: 3 cycles with no stall;
  - read: 3 + RD_LATENCY cycles;
  - stalls add 1 cycle each;
  - range error: 2 cycles.
- Error path:
  - core_rdata_o = ERR_RDATA; core_ready_o is still pulsed so the core does not hang.
  - If err_o=0: set err_o, err_type_o, err_addr_o and err_instr_o.
  - If err_o=1: keep the first error's information (no overwrite).
  - Error writes never reach memory.
- err_clr_i:
  - Clears err_o and err_type_o on the next edge.
  - If a new error and err_clr_i occur on the same edge, the new error wins and is latched.
- Reset mid-operation:
  - All state returns to reset values immediately (asynchronous).
  - mem_en_o falls without handshake; any in-flight read data is discarded.
- Writes wider than the strobe pattern are the memory's concern; the bridge passes strobes unchanged.

Test Plan:
- Read, RD_LATENCY=1, no stall: core reads 0x100, memory returns 0xCAFE_0001 one cycle after accept -> mem_en_o high for 1 cycle; core_ready_o pulses 4 cycles after valid with rdata 0xCAFE_0001.
- Write with stall: write 0x200, wstrb 4'b0011, mem_stall_i high for 3 cycles -> mem_en_o high 4 cycles with mem_we_o=0011; core_ready_o pulses once the cycle after the accepting edge.
- Latency sweep: RD_LATENCY=4, read 0x40 -> rdata sampled exactly 4 cycles after accept; ready at valid+7; a stall pulse asserted during WAIT has no effect.
- Range error: read 0x0001_0000 -> no mem_en_o; ready after 2 cycles with 0xDEAD_BEEF; err_o=1, err_type_o=01, err_addr_o=0x0001_0000. A second error at 0x0002_0000 leaves err_addr_o unchanged; err_clr_i clears err_o and err_type_o.
- Timeout: TIMEOUT_CYC=8, fetch 0x80 with mem_stall_i stuck high -> mem_en_o drops after 8 stalled cycles; ready with 0xDEAD_BEEF; err_type_o=10, err_instr_o=1.
- Reset in WAIT: resetn_i low during a RD_LATENCY=3 read -> all outputs 0 within the same cycle; after release, a new read completes normally and the stale data is never presented.
